// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 encodings, LSU FSM states and
// access-size decode helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Reserved encodings (011, 110, 111) fall through to word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant bus between the LSU (master) and memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load
// extract and sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  lsu_size_t   size;
  logic        uns;
  logic [31:0] sh;

  assign size = f3_size(funct3_i);
  assign uns  = funct3_i[2];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    sh      = rdata_i;
    rdata_o = rdata_i;
    case (size)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        sh      = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        sh      = rdata_i >> {addr_lo_i[1], 4'b0000};
        rdata_o = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences datapath loads/stores onto a req/gnt bus and
// stalls the PC meanwhile. LSU_MISALIGN_TRAP_EN enables the misalign trap.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              stall,
  output logic              misaligned,
  load_store_unit_if.master bus
);
  lsu_state_t        state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              access, mis, in_req;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep, rdata_fmt;

  assign access = MemRead | MemWrite;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = is_misaligned(funct3, ALUResult[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i  (funct3),
    .addr_lo_i (ALUResult[1:0]),
    .wdata_i   (WriteData),
    .rdata_i   (bus.bus_rdata),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (rdata_fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        // A trapped access skips the bus and reports in DONE with zeroed data.
        if (mis) begin
          state_d = DONE;
          rdata_d = '0;
          mis_d   = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      REQ:  if (bus.bus_gnt) state_d = MemWrite ? DONE : WAIT;
      WAIT: if (bus.bus_rvalid) begin
        state_d = DONE;
        rdata_d = rdata_fmt;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_req     = (state_q == REQ);
  assign stall      = ((state_q == IDLE) & access) | in_req | (state_q == WAIT);
  assign ReadData   = rdata_q;
  assign misaligned = mis_q;

  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & MemWrite;
  assign bus.bus_addr  = in_req ? {ALUResult[ADDR_W-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? be : 4'b0000;
  assign bus.bus_wdata = in_req ? wdata_rep : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk, rst_n, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        stall, misaligned;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  int          n_chk, n_fail;

  load_store_unit_if bus_if ();
  assign bus_if.bus_gnt    = gnt;
  assign bus_if.bus_rvalid = rvalid;
  assign bus_if.bus_rdata  = rdata;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .stall(stall), .misaligned(misaligned), .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last run_access call.
  int          r_stall, r_req;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic        r_we, r_mis, r_early;

  // Drives one access, grants after gnt_dly REQ cycles and returns read data
  // rv_dly WAIT cycles later; ends on the DONE cycle, then returns to IDLE.
  task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gnt_dly, input int rv_dly);
    int gw, rw; logic granted, done; logic [31:0] prev;
    @(negedge clk);
    MemRead = ~wr; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
    rdata = rd; gw = 0; rw = 0; granted = 0; done = 0; prev = ReadData;
    r_stall = 0; r_req = 0; r_be = '0; r_addr = '0; r_wdata = '0; r_we = 0; r_early = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) begin done = 1; break; end
      r_stall++;
      if (ReadData !== prev) r_early = 1;
      gnt = 0; rvalid = 0;
      if (bus_if.bus_req) begin
        r_req++; r_be = bus_if.bus_be; r_addr = bus_if.bus_addr;
        r_wdata = bus_if.bus_wdata; r_we = bus_if.bus_we;
        if (gw == gnt_dly) gnt = 1;
        gw++;
      end else if (granted) begin
        if (rw == rv_dly) rvalid = 1;
        rw++;
      end
      if (gnt) granted = 1;
      @(negedge clk);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL access_timeout: stall still %b after 64 cycles, required 0", stall);
    end
    r_rd = ReadData; r_mis = misaligned;
    MemRead = 0; MemWrite = 0; gnt = 0; rvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", bus_if.bus_req); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b required 0", stall); end
    n_chk++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_rd: got %h required 0", ReadData); end
    n_chk++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b required 0", misaligned); end
    n_chk++; if ({bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata} !== '0) begin
      n_fail++; $display("FAIL rst_bus: bus outputs nonzero be=%h addr=%h", bus_if.bus_be, bus_if.bus_addr); end
    @(negedge clk);
    rst_n = 1; MemRead = 1; funct3 = F3_W; ALUResult = 32'h10;
    @(negedge clk); #1;
    n_chk++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b required 1", bus_if.bus_req); end
    rst_n = 0; #1;
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %b required 0", bus_if.bus_req); end
    MemRead = 0; rvalid = 1; rdata = 32'hFFFF_FFFF;
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_post_stall: got %b required 0", stall); end
    n_chk++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_late_rvalid: got %h required 0", ReadData); end
    rvalid = 0;
  endtask

  task automatic test_store_word();
    run_access(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    n_chk++; if (r_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b required 1111", r_be); end
    n_chk++; if (r_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h required 100", r_addr); end
    n_chk++; if (r_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h required deadbeef", r_wdata); end
    n_chk++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b required 1", r_we); end
    n_chk++; if (r_stall != 2) begin n_fail++; $display("FAIL sw_stall: got %0d cycles required 2", r_stall); end
    run_access(1'b1, F3_B, 32'h101, 32'h0000_005A, 32'h0, 0, 0);
    n_chk++; if (r_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b required 0010", r_be); end
    n_chk++; if (r_wdata !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL sb_wdata: got %h required 5a5a5a5a", r_wdata); end
  endtask

  task automatic test_load_byte_half();
    run_access(1'b0, F3_B, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
    n_chk++; if (r_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext: got %h required ffffff80", r_rd); end
    n_chk++; if (r_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b required 1000", r_be); end
    n_chk++; if (r_stall != 3) begin n_fail++; $display("FAIL lb_stall: got %0d cycles required 3", r_stall); end
    n_chk++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b required 0", r_we); end
    run_access(1'b0, F3_BU, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
    n_chk++; if (r_rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h required 00000080", r_rd); end
    run_access(1'b0, F3_H, 32'h202, 32'h0, 32'h80FF_1234, 0, 0);
    n_chk++; if (r_rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_sext: got %h required ffff80ff", r_rd); end
    run_access(1'b0, F3_HU, 32'h202, 32'h0, 32'h80FF_1234, 0, 0);
    n_chk++; if (r_rd !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_zext: got %h required 000080ff", r_rd); end
  endtask

  task automatic test_store_half_delayed();
    run_access(1'b1, F3_H, 32'h302, 32'h0000_ABCD, 32'h0, 3, 0);
    n_chk++; if (r_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b required 1100", r_be); end
    n_chk++; if (r_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h required abcdabcd", r_wdata); end
    n_chk++; if (r_req != 4) begin n_fail++; $display("FAIL sh_req_cycles: got %0d required 4", r_req); end
    n_chk++; if (r_stall != 5) begin n_fail++; $display("FAIL sh_stall: got %0d cycles required 5", r_stall); end
  endtask

  task automatic test_load_word_late();
    run_access(1'b0, F3_W, 32'h500, 32'h0, 32'h1234_5678, 0, 3);
    n_chk++; if (r_rd !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_data: got %h required 12345678", r_rd); end
    n_chk++; if (r_early !== 1'b0) begin n_fail++; $display("FAIL lw_early_capture: ReadData changed before rvalid"); end
    n_chk++; if (r_stall != 6) begin n_fail++; $display("FAIL lw_stall: got %0d cycles required 6", r_stall); end
    // Spurious rvalid while idle must not touch ReadData.
    rvalid = 1; rdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    rvalid = 0; #1;
    n_chk++; if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL idle_rvalid: got %h required 12345678", ReadData); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b required 0", stall); end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, F3_W, 32'h401, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_chk++; if (r_mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b required 1", r_mis); end
    n_chk++; if (r_req != 0) begin n_fail++; $display("FAIL mis_no_req: got %0d req cycles required 0", r_req); end
    n_chk++; if (r_rd !== 32'h0) begin n_fail++; $display("FAIL mis_rd: got %h required 0", r_rd); end
    n_chk++; if (r_stall != 1) begin n_fail++; $display("FAIL mis_stall: got %0d required 1", r_stall); end
`else
    n_chk++; if (r_mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b required 0", r_mis); end
    n_chk++; if (r_addr !== 32'h400) begin n_fail++; $display("FAIL mis_addr: got %h required 400", r_addr); end
    n_chk++; if (r_rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mis_rd: got %h required cafef00d", r_rd); end
    n_chk++; if (r_stall != 3) begin n_fail++; $display("FAIL mis_stall: got %0d required 3", r_stall); end
`endif
    n_chk++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b required 0", misaligned); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 0; MemRead = 0; MemWrite = 0; funct3 = '0; ALUResult = '0; WriteData = '0;
    gnt = 0; rvalid = 0; rdata = '0;
    test_reset();
    test_store_word();
    test_load_byte_half();
    test_store_half_delayed();
    test_load_word_late();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
